// File: rtl/pe_weight_loader.sv
// PE weight loader: turns a valid/ready weight stream into per-PE
// kernel writes, PE-major, then row, then column.
module pe_weight_loader #(
    parameter  int DATA_WIDTH       = 16,
    parameter  int MAX_FILTER_WIDTH = 11,
    parameter  int NUM_PE           = 4,
    localparam int LOG_MFW          = $clog2(MAX_FILTER_WIDTH),
    localparam int LOG_NPE          = $clog2(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [LOG_MFW:0]      i_filter_width,
    input  logic [LOG_NPE:0]      i_num_pe,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
    output logic [DATA_WIDTH-1:0] o_weight_data,
    output logic                  o_weight_valid,
    output logic [LOG_MFW:0]      o_wr_w_row_ptr,
    output logic [LOG_MFW:0]      o_wr_w_col_ptr,
    output logic [NUM_PE-1:0]     o_pe_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int PW = LOG_MFW + 1;
    localparam int NW = LOG_NPE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           fw_q;
    logic [NW-1:0]           npe_q;
    logic [PW-1:0]           row_q;
    logic [PW-1:0]           col_q;
    logic [NW-1:0]           pe_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic [PW-1:0]           row_ptr_q;
    logic [PW-1:0]           col_ptr_q;
    logic [NUM_PE-1:0]       sel_q;
    logic                    done_q;
    logic                    err_q;

    logic accept;
    logic legal;
    logic last_col;
    logic last_row;
    logic last_pe;

    assign o_w_ready = (state_q == LOAD);
    assign accept    = i_w_valid && o_w_ready;
    assign o_busy    = (state_q != IDLE);

    assign legal = (i_filter_width != '0)
                && (i_filter_width <= PW'(MAX_FILTER_WIDTH))
                && (i_num_pe != '0)
                && (i_num_pe <= NW'(NUM_PE));

    assign last_col = (col_q == fw_q - PW'(1));
    assign last_row = (row_q == fw_q - PW'(1));
    assign last_pe  = (pe_q == npe_q - NW'(1));

    assign o_weight_data  = data_q;
    assign o_weight_valid = valid_q;
    assign o_wr_w_row_ptr = row_ptr_q;
    assign o_wr_w_col_ptr = col_ptr_q;
    assign o_pe_sel       = sel_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            fw_q      <= '0;
            npe_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pe_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            row_ptr_q <= '0;
            col_ptr_q <= '0;
            sel_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes default low; data and ptrs hold between writes.
            valid_q <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (legal) begin
                            fw_q    <= i_filter_width;
                            npe_q   <= i_num_pe;
                            row_q   <= '0;
                            col_q   <= '0;
                            pe_q    <= '0;
                            state_q <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        data_q    <= i_w_data;
                        valid_q   <= 1'b1;
                        row_ptr_q <= row_q;
                        col_ptr_q <= col_q;
                        sel_q     <= NUM_PE'(1) << pe_q;
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q <= '0;
                                pe_q  <= pe_q + NW'(1);
                                if (last_pe) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                row_q <= row_q + PW'(1);
                            end
                        end else begin
                            col_q <= col_q + PW'(1);
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed self-checking bench for pe_weight_loader.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_pe_weight_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [4:0]  i_filter_width;
    logic [2:0]  i_num_pe;
    logic [15:0] i_w_data;
    logic        i_w_valid;
    logic        o_w_ready;
    logic [15:0] o_weight_data;
    logic        o_weight_valid;
    logic [4:0]  o_wr_w_row_ptr;
    logic [4:0]  o_wr_w_col_ptr;
    logic [3:0]  o_pe_sel;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_weight_loader #(
        .DATA_WIDTH(16),
        .MAX_FILTER_WIDTH(11),
        .NUM_PE(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_filter_width(i_filter_width),
        .i_num_pe(i_num_pe),
        .i_w_data(i_w_data),
        .i_w_valid(i_w_valid),
        .o_w_ready(o_w_ready),
        .o_weight_data(o_weight_data),
        .o_weight_valid(o_weight_valid),
        .o_wr_w_row_ptr(o_wr_w_row_ptr),
        .o_wr_w_col_ptr(o_wr_w_col_ptr),
        .o_pe_sel(o_pe_sel),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err)
    );

    // {valid, data, row, col, sel, busy, done, err, ready}
    function automatic logic [35:0] outs();
        return {o_weight_valid, o_weight_data, o_wr_w_row_ptr,
                o_wr_w_col_ptr, o_pe_sel, o_busy, o_done, o_err, o_w_ready};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        i_start = 1'b0;
        i_filter_width = '0;
        i_num_pe = '0;
        i_w_data = '0;
        i_w_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs() !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0", outs());
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs() !== 36'h0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h want 0", outs());
        end
    endtask

    // Full load with the model-derived write sequence; gap inserts an
    // idle (valid=0) cycle after every beat except the last.
    task automatic test_load(input int fw, input int npe, input bit gap);
        int total;
        int dones;
        logic [4:0] er, ec;
        logic [3:0] es;
        total = npe * fw * fw;
        dones = 0;
        i_filter_width = 5'(fw);
        i_num_pe = 3'(npe);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_filter_width = 5'd0;
        i_num_pe = 3'd7;
        n_cmp++;
        if (o_busy !== 1'b1 || o_w_ready !== 1'b1 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL start_fw%0d_npe%0d: busy=%b ready=%b err=%b want 1 1 0",
                     fw, npe, o_busy, o_w_ready, o_err);
        end
        for (int b = 0; b < total; b++) begin
            es = 4'(1 << (b / (fw * fw)));
            er = 5'((b % (fw * fw)) / fw);
            ec = 5'(b % fw);
            i_w_valid = 1'b1;
            i_w_data = 16'(b + 1);
            @(negedge clk);
            if (o_done) dones++;
            n_cmp++;
            if ({o_weight_valid, o_weight_data, o_wr_w_row_ptr,
                 o_wr_w_col_ptr, o_pe_sel, o_done} !==
                {1'b1, 16'(b + 1), er, ec, es, b == total - 1}) begin
                n_bad++;
                $display("FAIL write_fw%0d_b%0d: v=%b d=%0d r=%0d c=%0d s=%b dn=%b want 1 %0d %0d %0d %b %b",
                         fw, b, o_weight_valid, o_weight_data, o_wr_w_row_ptr,
                         o_wr_w_col_ptr, o_pe_sel, o_done,
                         b + 1, er, ec, es, b == total - 1);
            end
            if (gap && b != total - 1) begin
                i_w_valid = 1'b0;
                i_w_data = 16'hdead;
                @(negedge clk);
                if (o_done) dones++;
                n_cmp++;
                if ({o_weight_valid, o_pe_sel, o_wr_w_row_ptr,
                     o_wr_w_col_ptr, o_weight_data} !==
                    {1'b0, 4'b0, er, ec, 16'(b + 1)}) begin
                    n_bad++;
                    $display("FAIL gap_b%0d: v=%b s=%b r=%0d c=%0d d=%0d want 0 0 %0d %0d %0d",
                             b, o_weight_valid, o_pe_sel, o_wr_w_row_ptr,
                             o_wr_w_col_ptr, o_weight_data, er, ec, b + 1);
                end
            end
        end
        n_cmp++;
        if (o_busy !== 1'b1 || o_w_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL done_state: busy=%b ready=%b want 1 0", o_busy, o_w_ready);
        end
        i_w_valid = 1'b0;
        @(negedge clk);
        if (o_done) dones++;
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_weight_valid !== 1'b0 ||
            o_w_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL after_done: busy=%b done=%b v=%b rdy=%b want 0 0 0 0",
                     o_busy, o_done, o_weight_valid, o_w_ready);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL done_count_fw%0d: got %0d want 1", fw, dones);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] fws[4] = '{5'd0, 5'd12, 5'd3, 5'd3};
        logic [2:0] nps[4] = '{3'd1, 3'd1, 3'd5, 3'd0};
        for (int k = 0; k < 4; k++) begin
            i_filter_width = fws[k];
            i_num_pe = nps[k];
            i_w_valid = 1'b1;
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            n_cmp++;
            if ({o_err, o_busy, o_w_ready, o_weight_valid} !== 4'b1000) begin
                n_bad++;
                $display("FAIL illegal_%0d: err/busy/rdy/v=%b want 1000",
                         k, {o_err, o_busy, o_w_ready, o_weight_valid});
            end
            @(negedge clk);
            n_cmp++;
            if ({o_err, o_busy, o_w_ready} !== 3'b000) begin
                n_bad++;
                $display("FAIL illegal_clr_%0d: err/busy/rdy=%b want 000",
                         k, {o_err, o_busy, o_w_ready});
            end
        end
        i_w_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        i_filter_width = 5'd1;
        i_num_pe = 3'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_w_valid = 1'b1;
        i_w_data = 16'h00aa;
        @(negedge clk);
        i_w_valid = 1'b0;
        n_cmp++;
        if ({o_done, o_busy, o_pe_sel} !== 6'b11_0001) begin
            n_bad++;
            $display("FAIL b2b_first: done/busy/sel=%b want 110001",
                     {o_done, o_busy, o_pe_sel});
        end
        // Start raised during DONE must wait for IDLE.
        i_num_pe = 3'd2;
        i_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_w_ready, o_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL b2b_idle: busy/rdy/err=%b want 000",
                     {o_busy, o_w_ready, o_err});
        end
        @(negedge clk);
        i_start = 1'b0;
        n_cmp++;
        if ({o_busy, o_w_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_second_start: busy/rdy=%b want 11",
                     {o_busy, o_w_ready});
        end
        for (int b = 0; b < 2; b++) begin
            i_w_valid = 1'b1;
            i_w_data = 16'(16'h0b0 + b);
            @(negedge clk);
            n_cmp++;
            if ({o_weight_data, o_pe_sel, o_done} !==
                {16'(16'h0b0 + b), 4'(1 << b), b == 1}) begin
                n_bad++;
                $display("FAIL b2b_write%0d: d=%h sel=%b done=%b", b,
                         o_weight_data, o_pe_sel, o_done);
            end
        end
        i_w_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        i_filter_width = 5'd3;
        i_num_pe = 3'd2;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            i_w_valid = 1'b1;
            i_w_data = 16'(b + 100);
            @(negedge clk);
        end
        i_w_valid = 1'b0;
        i_filter_width = 5'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n_cmp++;
        if ({o_busy, o_w_ready, o_err, o_weight_valid} !== 4'b1100) begin
            n_bad++;
            $display("FAIL start_ignored: busy/rdy/err/v=%b want 1100",
                     {o_busy, o_w_ready, o_err, o_weight_valid});
        end
        i_w_valid = 1'b1;
        i_w_data = 16'd105;
        @(negedge clk);
        n_cmp++;
        if ({o_wr_w_row_ptr, o_wr_w_col_ptr, o_pe_sel} !== {5'd1, 5'd2, 4'b0001}) begin
            n_bad++;
            $display("FAIL no_restart: r=%0d c=%0d sel=%b want 1 2 0001",
                     o_wr_w_row_ptr, o_wr_w_col_ptr, o_pe_sel);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 36'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", outs());
        end
        i_w_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_load(3, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load(3, 2, 1'b0);
        test_load(3, 2, 1'b1);
        test_illegal();
        test_load(1, 4, 1'b0);
        test_abort();
        test_back_to_back();
        test_load(11, 4, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
